// File: rtl/framebuffer_arbiter_pkg.sv
// Shared types and defaults for the framebuffer arbiter: geometry defaults,
// FSM state encoding, the read-return tag, and the address-width check.
package framebuffer_arbiter_pkg;

  localparam int H_PIXELS_DEF = 320;
  localparam int V_PIXELS_DEF = 240;
  localparam int ADDR_W_DEF   = 17;
  localparam int DATA_W_DEF   = 8;
  localparam int RD_LAT_DEF   = 1;
  localparam int LB_IDX_W     = 9;

  // FSM states kept as plain constants so older code can compare raw bits.
  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 1'b0;
  localparam fsm_state_t ST_FETCH = 1'b1;

  // Travels alongside every RAM read so the returning data can be routed.
  typedef struct packed {
    logic                valid;
    logic                is_host;
    logic [LB_IDX_W-1:0] lb_idx;
  } rd_tag_t;

  // True when a full frame of pixels fits in the RAM address space.
  function automatic bit addr_w_fits(input int h, input int v, input int aw);
    return (longint'(h) * longint'(v)) <= (longint'(1) << aw);
  endfunction

  localparam bit ADDR_W_DEF_OK = addr_w_fits(H_PIXELS_DEF, V_PIXELS_DEF, ADDR_W_DEF);

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Bundle of the line-fetch, host, RAM and line-buffer signals of the arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface framebuffer_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);
  logic              line_req;
  logic [7:0]        line_idx;
  logic              line_done;
  logic              fetch_overrun;

  logic              host_valid;
  logic              host_ready;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              lb_we;
  logic [8:0]        lb_addr;
  logic [DATA_W-1:0] lb_wdata;

  modport slave (
    input  line_req, line_idx, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    output line_done, fetch_overrun, host_ready, host_rvalid, host_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
  );

  modport master (
    output line_req, line_idx, host_valid, host_we, host_addr, host_wdata, mem_rdata,
    input  line_done, fetch_overrun, host_ready, host_rvalid, host_rdata,
           mem_ce, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
  );
endinterface

// File: rtl/framebuffer_arbiter_rd_tag_pipe.sv
// Delay line for read tags, RD_LAT stages deep, so each tag emerges in the
// same cycle as the RAM data it describes.
module framebuffer_arbiter_rd_tag_pipe
  import framebuffer_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic    CLOCK,
  input  logic    RESET_N,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_r [RD_LAT];

  // Shift tags one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign tag_out = pipe_r[RD_LAT-1];

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer RAM arbiter. A line request streams one display
// line into the scan-out line buffer with absolute priority; host accesses
// take the slots left over. All RAM and line-buffer outputs are registered.
module framebuffer_arbiter
  import framebuffer_arbiter_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_PIXELS = V_PIXELS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic                 CLOCK,
  input  logic                 RESET_N,
  framebuffer_arbiter_if.slave bus
);

  localparam logic [LB_IDX_W-1:0] X_LAST  = LB_IDX_W'(H_PIXELS - 1);
  localparam logic [8:0]          V_LIM   = 9'(V_PIXELS);
  localparam logic [ADDR_W-1:0]   H_PIX_A = ADDR_W'(H_PIXELS);

  // control state
  fsm_state_t          state_r,   state_nx_s;
  logic                pending_r, pending_nx_s;
  logic [ADDR_W-1:0]   base_r,    base_nx_s;
  logic [LB_IDX_W-1:0] x_r,       x_nx_s;
  logic                overrun_r, overrun_nx_s;
  logic                host_ready_r, host_ready_nx_s;
  logic                fetch_issue_s;
  logic                host_issue_s;
  rd_tag_t             issue_tag_s;

  // issue register
  logic                mem_ce_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  rd_tag_t             issue_tag_r;

  // return register
  rd_tag_t             ret_tag_s;
  logic                lb_wr_s;
  logic                host_ret_s;
  logic                lb_we_r;
  logic [8:0]          lb_addr_r;
  logic [DATA_W-1:0]   lb_wdata_r;
  logic                line_done_r;
  logic                host_rvalid_r;
  logic [DATA_W-1:0]   host_rdata_r;

  // Decide this cycle's RAM slot owner and the next FSM/pending/counter values.
  always_comb begin
    state_nx_s    = state_r;
    pending_nx_s  = pending_r;
    base_nx_s     = base_r;
    x_nx_s        = x_r;
    overrun_nx_s  = overrun_r;
    fetch_issue_s = 1'b0;
    host_issue_s  = 1'b0;

    if (pending_r) begin
      // Pixel 0 issues from the pending cycle; x_r is already 0 here.
      fetch_issue_s = 1'b1;
      pending_nx_s  = 1'b0;
      state_nx_s    = ST_FETCH;
      x_nx_s        = 9'd1;
    end else if (state_r == ST_FETCH) begin
      fetch_issue_s = 1'b1;
      if (x_r == X_LAST) begin
        state_nx_s = ST_IDLE;
        x_nx_s     = 9'd0;
      end else begin
        x_nx_s = x_r + 9'd1;
      end
    end else begin
      host_issue_s = bus.host_valid && host_ready_r;
    end

    if (bus.line_req) begin
      if (pending_r || (state_r == ST_FETCH)) begin
        overrun_nx_s = 1'b1;
      end else if ({1'b0, bus.line_idx} < V_LIM) begin
        pending_nx_s = 1'b1;
        base_nx_s    = ADDR_W'(bus.line_idx) * H_PIX_A;
      end else begin
        pending_nx_s = pending_r;
      end
    end else begin
      overrun_nx_s = overrun_r;
    end

    // Registered copy of "idle and nothing pending" so READY never looks at VALID.
    host_ready_nx_s = (state_nx_s == ST_IDLE) && !pending_nx_s;

    issue_tag_s.valid   = fetch_issue_s || (host_issue_s && !bus.host_we);
    issue_tag_s.is_host = host_issue_s;
    issue_tag_s.lb_idx  = fetch_issue_s ? x_r : 9'd0;
  end

  // FSM, pending flag, line base, pixel counter, overrun flag and READY.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      pending_r    <= 1'b0;
      base_r       <= '0;
      x_r          <= 9'd0;
      overrun_r    <= 1'b0;
      host_ready_r <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      pending_r    <= pending_nx_s;
      base_r       <= base_nx_s;
      x_r          <= x_nx_s;
      overrun_r    <= overrun_nx_s;
      host_ready_r <= host_ready_nx_s;
    end
  end

  // Present the chosen access to the RAM one cycle after the decision.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_ce_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      issue_tag_r <= '0;
    end else begin
      mem_ce_r <= fetch_issue_s || host_issue_s;
      mem_we_r <= host_issue_s && bus.host_we;
      if (fetch_issue_s) begin
        mem_addr_r <= base_r + ADDR_W'(x_r);
      end else if (host_issue_s) begin
        mem_addr_r <= bus.host_addr;
      end else begin
        mem_addr_r <= '0;
      end
      mem_wdata_r <= (host_issue_s && bus.host_we) ? bus.host_wdata : '0;
      issue_tag_r <= issue_tag_s;
    end
  end

  framebuffer_arbiter_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .tag_in  (issue_tag_r),
    .tag_out (ret_tag_s)
  );

  assign lb_wr_s    = ret_tag_s.valid && !ret_tag_s.is_host;
  assign host_ret_s = ret_tag_s.valid && ret_tag_s.is_host;

  // Capture returning RAM data once and steer it to the line buffer or host.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      lb_we_r       <= 1'b0;
      lb_addr_r     <= 9'd0;
      lb_wdata_r    <= '0;
      line_done_r   <= 1'b0;
      host_rvalid_r <= 1'b0;
      host_rdata_r  <= '0;
    end else begin
      lb_we_r       <= lb_wr_s;
      lb_addr_r     <= lb_wr_s ? ret_tag_s.lb_idx : 9'd0;
      lb_wdata_r    <= lb_wr_s ? bus.mem_rdata : '0;
      line_done_r   <= lb_wr_s && (ret_tag_s.lb_idx == X_LAST);
      host_rvalid_r <= host_ret_s;
      host_rdata_r  <= host_ret_s ? bus.mem_rdata : host_rdata_r;
    end
  end

  assign bus.mem_ce        = mem_ce_r;
  assign bus.mem_we        = mem_we_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.mem_wdata     = mem_wdata_r;
  assign bus.host_ready    = host_ready_r;
  assign bus.fetch_overrun = overrun_r;
  assign bus.lb_we         = lb_we_r;
  assign bus.lb_addr       = lb_addr_r;
  assign bus.lb_wdata      = lb_wdata_r;
  assign bus.line_done     = line_done_r;
  assign bus.host_rvalid   = host_rvalid_r;
  assign bus.host_rdata    = host_rdata_r;

endmodule
